uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared 8N1 framing constants and transmitter FSM encodings.
// Imported by the transmitter, its buffer and any companion receiver.
package uart_tx_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  function automatic logic uart_on_line(input logic [1:0] st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte buffer, first-word fall-through read; flags registered via count.
// Writes while full are dropped even if a pop happens in the same cycle.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  uart_byte_t wr_data_i,
  input  logic       rd_en_i,
  output uart_byte_t rd_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  uart_byte_t    mem_q [FIFO_DEPTH];

  logic wr_ok;
  logic rd_ok;

  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter; tx falls 2 cycles after a write into an idle empty buffer.
// tx_full flags a full buffer (further writes dropped); tx_en gates new frames only.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       txing,
  output logic       tx_success
);

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  uart_byte_t shift_q, shift_d;
  logic       tx_q, tx_d;

  logic       fifo_rd;
  uart_byte_t fifo_dout;
  logic       bit_end;
  logic       can_start;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (tx_wr & ~reset),
    .wr_data_i (tx_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_dout),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  assign bit_end   = (cnt_q == CNT_LAST);
  assign can_start = tx_en & ~tx_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? 8'd0 : cnt_q + 8'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (can_start) begin
          state_d = ST_START;
          fifo_rd = 1'b1;
          shift_d = fifo_dout;
          tx_d    = UART_START_BIT;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = UART_STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_STOP: begin
        // Chaining straight into the next start bit leaves no idle gap.
        if (bit_end) begin
          if (can_start) begin
            state_d = ST_START;
            fifo_rd = 1'b1;
            shift_d = fifo_dout;
            tx_d    = UART_START_BIT;
          end else begin
            state_d = ST_IDLE;
            tx_d    = UART_IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign txing      = uart_on_line(state_q);
  assign tx_success = (state_q == ST_STOP) & bit_end;

endmodule
